// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
// Holds the sequencer state encoding and the saturating score adder.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HOME,
        S_RESPAWN,
        S_CLEAR,
        S_WIN,
        S_OVER
    } state_t;

    localparam int HOME_PTS_DEF  = 50;
    localparam int STAGE_PTS_DEF = 1000;

    localparam logic [4:0] ALL_HOMES = 5'h1F;

    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down counter that stops at zero.
// Used for both the per-life round timer and the respawn hold.
module frame_down_counter #(
    parameter int W    = 8,
    parameter int INIT = 1
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic         load,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         zero
);

    localparam logic [W-1:0] INIT_V = W'(INIT);

    always_ff @(posedge frame_clk) begin
        if (Reset || load) begin
            value <= INIT_V;
        end else if (en && value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: title, play, respawn, stage clear, win/game-over.
// Drives detection control pulses, the round timer and the running score.
module game_sequencer
    import game_pkg::*;
#(
    parameter int ROUND_FRAMES   = 1800,
    parameter int RESPAWN_FRAMES = 30,
    parameter int HOME_PTS       = HOME_PTS_DEF,
    parameter int STAGE_PTS      = STAGE_PTS_DEF,
    parameter int TIMER_W        = 11
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               frogreset,
    input  logic [3:0]         Life,
    input  logic [4:0]         safe,
    output logic               freeze,
    output logic               time_up,
    output logic               winreset,
    output logic               winx,
    output logic               gameoverx,
    output logic               stage2x,
    output logic [TIMER_W-1:0] round_time,
    output logic [15:0]        score
);

    localparam int RESP_W = $clog2(RESPAWN_FRAMES) + 1;

    localparam logic [15:0] HOME_V  = 16'(HOME_PTS);
    localparam logic [15:0] STAGE_V = 16'(STAGE_PTS);

    state_t            state;
    logic              fr_q;
    logic              start_q;
    logic [4:0]        safe_q;
    logic              evt;
    logic              new_home;
    logic              round_load;
    logic              round_en;
    logic              round_zero;
    logic              resp_load;
    logic              resp_en;
    logic              resp_zero;
    logic [RESP_W-1:0] resp_cnt_unused;

    assign evt      = frogreset & ~fr_q;
    assign new_home = (safe & ~safe_q) != 5'd0;

    assign round_load = (state == S_IDLE && start)
                     || (state == S_RESPAWN && resp_zero);
    assign round_en   = (state == S_PLAY) && !evt && !round_zero;

    // Respawn hold is preloaded whenever idle so it runs exactly N frames
    assign resp_load = (state != S_RESPAWN);
    assign resp_en   = (state == S_RESPAWN);

    frame_down_counter #(
        .W    (TIMER_W),
        .INIT (ROUND_FRAMES)
    ) u_round (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (round_load),
        .en        (round_en),
        .value     (round_time),
        .zero      (round_zero)
    );

    frame_down_counter #(
        .W    (RESP_W),
        .INIT (RESPAWN_FRAMES - 1)
    ) u_respawn (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .load      (resp_load),
        .en        (resp_en),
        .value     (resp_cnt_unused),
        .zero      (resp_zero)
    );

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            freeze    <= 1'b1;
            time_up   <= 1'b0;
            winreset  <= 1'b0;
            winx      <= 1'b0;
            gameoverx <= 1'b0;
            stage2x   <= 1'b0;
            score     <= '0;
            fr_q      <= 1'b0;
            start_q   <= 1'b0;
            safe_q    <= '0;
        end else begin
            fr_q      <= frogreset;
            start_q   <= start;
            time_up   <= 1'b0;
            winreset  <= 1'b0;
            winx      <= 1'b0;
            gameoverx <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_PLAY;
                        freeze  <= 1'b0;
                        score   <= '0;
                        stage2x <= 1'b0;
                        safe_q  <= '0;
                    end
                end
                S_PLAY: begin
                    if (evt) begin
                        freeze <= 1'b1;
                        if (Life == 4'd0) begin
                            state     <= S_OVER;
                            gameoverx <= 1'b1;
                        end else if (new_home) begin
                            state <= S_HOME;
                        end else begin
                            state <= S_RESPAWN;
                        end
                    end else begin
                        safe_q <= safe;
                        if (round_time == TIMER_W'(1)) begin
                            time_up <= 1'b1;
                        end
                    end
                end
                S_HOME: begin
                    score <= sat_add(score, HOME_V);
                    state <= (safe == ALL_HOMES) ? S_CLEAR : S_RESPAWN;
                end
                S_RESPAWN: begin
                    if (resp_zero) begin
                        state  <= S_PLAY;
                        freeze <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (!stage2x) begin
                        winreset <= 1'b1;
                        stage2x  <= 1'b1;
                        score    <= sat_add(score, STAGE_V);
                        safe_q   <= '0;
                        state    <= S_RESPAWN;
                    end else begin
                        winx  <= 1'b1;
                        state <= S_WIN;
                    end
                end
                S_WIN, S_OVER: begin
                    if (start && !start_q) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a spec-level reference model.
// Directed play-through covering death, homes, stage clears, win, game over.
module tb_game_sequencer;

    localparam int RF  = 8;
    localparam int RSP = 3;
    localparam int TW  = 11;

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_HOME  = 2;
    localparam int M_RESP  = 3;
    localparam int M_CLEAR = 4;
    localparam int M_WIN   = 5;
    localparam int M_OVER  = 6;

    logic          frame_clk = 1'b0;
    logic          Reset;
    logic          start;
    logic          frogreset;
    logic [3:0]    Life;
    logic [4:0]    safe;
    logic          freeze;
    logic          time_up;
    logic          winreset;
    logic          winx;
    logic          gameoverx;
    logic          stage2x;
    logic [TW-1:0] round_time;
    logic [15:0]   score;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 0;

    // reference model state
    int       m_mode   = M_IDLE;
    int       m_timer  = RF;
    int       m_score  = 0;
    int       m_frozen = 0;
    bit       m_stage2 = 0;
    bit       m_fr     = 0;
    bit       m_start  = 0;
    bit       m_tu     = 0;
    bit       m_wr     = 0;
    bit       m_wx     = 0;
    bit       m_go     = 0;
    logic [4:0] m_seen = '0;

    game_sequencer #(
        .ROUND_FRAMES   (RF),
        .RESPAWN_FRAMES (RSP),
        .HOME_PTS       (50),
        .STAGE_PTS      (1000),
        .TIMER_W        (TW)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .start      (start),
        .frogreset  (frogreset),
        .Life       (Life),
        .safe       (safe),
        .freeze     (freeze),
        .time_up    (time_up),
        .winreset   (winreset),
        .winx       (winx),
        .gameoverx  (gameoverx),
        .stage2x    (stage2x),
        .round_time (round_time),
        .score      (score)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic int add_pts(input int s, input int p);
        return (s + p > 65535) ? 65535 : s + p;
    endfunction

    task automatic go_respawn();
        m_mode   = M_RESP;
        m_frozen = 0;
    endtask

    task automatic model_step();
        bit evt;
        m_tu = 0;
        m_wr = 0;
        m_wx = 0;
        m_go = 0;
        evt  = frogreset && !m_fr;
        if (Reset) begin
            m_mode   = M_IDLE;
            m_timer  = RF;
            m_score  = 0;
            m_stage2 = 0;
            m_seen   = '0;
            m_fr     = 0;
            m_start  = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode   = M_PLAY;
                    m_score  = 0;
                    m_stage2 = 0;
                    m_timer  = RF;
                    m_seen   = '0;
                end
                M_PLAY: if (evt) begin
                    if (Life == 0) begin
                        m_mode = M_OVER;
                        m_go   = 1;
                    end else if ((safe & ~m_seen) != 0) begin
                        m_mode = M_HOME;
                    end else begin
                        go_respawn();
                    end
                end else begin
                    m_seen = safe;
                    if (m_timer > 0) begin
                        m_timer = m_timer - 1;
                        m_tu    = (m_timer == 0);
                    end
                end
                M_HOME: begin
                    m_score = add_pts(m_score, 50);
                    if (safe == 5'h1F) m_mode = M_CLEAR;
                    else go_respawn();
                end
                M_RESP: begin
                    m_frozen = m_frozen + 1;
                    if (m_frozen == RSP) begin
                        m_mode  = M_PLAY;
                        m_timer = RF;
                    end
                end
                M_CLEAR: if (!m_stage2) begin
                    m_wr     = 1;
                    m_stage2 = 1;
                    m_score  = add_pts(m_score, 1000);
                    m_seen   = '0;
                    go_respawn();
                end else begin
                    m_wx   = 1;
                    m_mode = M_WIN;
                end
                default: if (start && !m_start) m_mode = M_IDLE;
            endcase
            m_fr    = frogreset;
            m_start = start;
        end
    endtask

    initial forever begin
        @(posedge frame_clk);
        model_step();
    end

    initial forever begin
        @(negedge frame_clk);
        if (cmp_en) begin
            total++;
            if (freeze !== (m_mode != M_PLAY) || time_up !== m_tu
                || winreset !== m_wr || winx !== m_wx
                || gameoverx !== m_go || stage2x !== m_stage2
                || round_time !== TW'(m_timer) || score !== 16'(m_score)) begin
                bad++;
                $display("FAIL model t=%0t got fz%b tu%b wr%b wx%b go%b s2%b rt%0d sc%0d need fz%b tu%b wr%b wx%b go%b s2%b rt%0d sc%0d",
                    $time, freeze, time_up, winreset, winx, gameoverx, stage2x,
                    round_time, score, m_mode != M_PLAY, m_tu, m_wr, m_wx,
                    m_go, m_stage2, m_timer, m_score);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d need %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge frame_clk);
    endtask

    task automatic wait_play(input string name);
        int n;
        n = 0;
        while (freeze !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, freeze, 0);
    endtask

    task automatic frog_event(input logic [3:0] life, input logic [4:0] s_old,
                              input logic [4:0] s_new);
        frogreset = 0;
        safe      = s_old;
        tick();
        frogreset = 1;
        safe      = s_new;
        Life      = life;
        tick();
        frogreset = 0;
    endtask

    logic [4:0] homes [5] = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    logic [4:0] s1    [4] = '{5'b00101, 5'b00111, 5'b01111, 5'b11111};

    initial begin
        int cnt;
        int n;
        Reset = 1; start = 0; frogreset = 0; Life = 3; safe = 0;
        tick();
        tick();
        chk("rst_freeze", freeze, 1);
        chk("rst_round", round_time, RF);
        chk("rst_score", score, 0);
        chk("rst_stage2", stage2x, 0);
        Reset  = 0;
        cmp_en = 1;

        // first life times out
        start = 1;
        tick();
        start = 0;
        chk("start_freeze", freeze, 0);
        chk("start_round", round_time, RF);
        for (int i = RF - 1; i >= 0; i--) begin
            tick();
            chk("countdown", round_time, i);
            chk("time_up_at", time_up, (i == 0));
        end
        tick();
        tick();
        chk("time_up_once", time_up, 0);
        chk("round_hold0", round_time, 0);

        // death
        frog_event(2, 0, 0);
        for (int i = 0; i < RSP; i++) begin
            chk("death_freeze", freeze, 1);
            tick();
        end
        chk("death_play", freeze, 0);
        chk("death_round", round_time, RF);
        chk("death_score", score, 0);

        // home with frogreset held for 5 frames
        frogreset = 0; safe = 0; Life = 3;
        tick();
        frogreset = 1; safe = 5'b00100;
        tick();
        tick();
        chk("home_score", score, 50);
        tick();
        tick();
        tick();
        frogreset = 0;
        tick();
        tick();
        chk("hold_play", freeze, 0);
        chk("hold_score", score, 50);

        // stage 1 clear
        for (int i = 0; i < 3; i++) begin
            frog_event(3, (i == 0) ? 5'b00100 : s1[i-1], s1[i]);
            wait_play("s1_play");
        end
        frog_event(3, s1[2], s1[3]);
        tick();
        safe = 0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt += int'(winreset);
        end
        chk("winreset_once", cnt, 1);
        chk("stage2_set", stage2x, 1);
        chk("stage1_score", score, 1250);
        wait_play("s2_start");

        // stage 2 clear -> win
        for (int i = 0; i < 4; i++) begin
            frog_event(3, (i == 0) ? 5'b00000 : homes[i-1], homes[i]);
            wait_play("s2_play");
        end
        frog_event(3, homes[3], homes[4]);
        tick();
        safe = 0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt += int'(winx);
        end
        chk("winx_once", cnt, 1);
        chk("win_freeze", freeze, 1);
        chk("win_score", score, 1500);

        // win -> idle -> play
        start = 1;
        tick();
        tick();
        start = 0;
        chk("restart_score", score, 0);
        chk("restart_stage2", stage2x, 0);
        chk("restart_play", freeze, 0);

        // death on the frame the timer would expire
        n = 0;
        while (round_time != TW'(1) && n < 20) begin
            tick();
            n++;
        end
        chk("reach_one", round_time, 1);
        frogreset = 1;
        tick();
        frogreset = 0;
        chk("coinc_no_tu", time_up, 0);
        chk("coinc_round", round_time, 1);
        wait_play("coinc_play");

        // game over with start held
        frog_event(3, 0, 5'b00001);
        wait_play("go_home");
        start = 1;
        frog_event(0, 5'b00001, 5'b00001);
        chk("gameover_pulse", gameoverx, 1);
        tick();
        chk("gameover_one", gameoverx, 0);
        tick();
        tick();
        tick();
        chk("over_hold", freeze, 1);
        start = 0;
        tick();
        start = 1;
        tick();
        start = 0;
        tick();
        chk("idle_score", score, 50);
        chk("idle_freeze", freeze, 1);
        start = 1;
        tick();
        start = 0;
        chk("new_game_score", score, 0);
        Life = 3;

        // reset during respawn
        frog_event(3, 5'b00001, 5'b00001);
        tick();
        Reset = 1;
        tick();
        Reset = 0;
        chk("rst_resp_freeze", freeze, 1);
        chk("rst_resp_round", round_time, RF);
        start = 1;
        tick();
        start = 0;

        // reset during clear
        for (int i = 0; i < 4; i++) begin
            frog_event(3, (i == 0) ? 5'b00000 : homes[i-1], homes[i]);
            wait_play("rc_play");
        end
        frog_event(3, homes[3], homes[4]);
        tick();
        Reset = 1;
        tick();
        Reset = 0;
        safe = 0;
        chk("rst_clr_wr", winreset, 0);
        chk("rst_clr_s2", stage2x, 0);
        tick();
        chk("rst_clr_wr2", winreset, 0);
        chk("rst_clr_score", score, 0);

        // score saturation
        start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 1310; i++) begin
            frog_event(3, 0, 5'b00001);
            wait_play("sat_play");
        end
        chk("sat_pre", score, 65500);
        frog_event(3, 0, 5'b00001);
        wait_play("sat_play");
        chk("sat_clamp", score, 16'hFFFF);
        frog_event(3, 0, 5'b00001);
        wait_play("sat_play");
        chk("sat_hold", score, 16'hFFFF);

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
